jk_bank_sequencer: RTL and testbench
====================================

# jk_bank_sequencer

Sequencing controller for a bank of WIDTH `jk_flipflop` instances that share its clock. On a START command it drives the bank's J/K inputs to clear the bank, load it, count it up, or toggle a mask of bits a programmed number of times. It reads the bank's Q outputs back to compute each step and reports completion with a BUSY/DONE handshake. It sits between the project's command source and the flip-flop bank, and is the only driver of the bank's J and K inputs.

## Interface
- WIDTH, 4: number of flip-flops in the bank.
- CNT_W, 8: width of the step counter.

- CLK  input  1  clock; the bank uses the same clock and samples on the same posedge.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  command request; sampled only in IDLE.
- OP  input  2  command: 00 CLEAR, 01 LOAD, 10 COUNT, 11 TOGGLE.
- DATA  input  WIDTH  LOAD value, or TOGGLE mask.
- STEPS  input  CNT_W  number of COUNT/TOGGLE steps; ignored for CLEAR/LOAD.
- Q_IN  input  WIDTH  Q outputs of the bank; bit i comes from flip-flop i.
- J  output  WIDTH  registered J drive to the bank.
- K  output  WIDTH  registered K drive to the bank.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, DRIVE, HOLD, DONE.
- **IDLE.** J=K=0, so the bank holds its value.
  - START=1 at a posedge accepts the command. The edge latches OP, DATA and rem=STEPS.
  - CLEAR and LOAD force rem=1.
  - COUNT/TOGGLE with STEPS=0 go directly to DONE, with J and K never asserted.
  - Any other accepted command goes to DRIVE. J/K are computed from Q_IN sampled at that same edge.
- **J/K computation** (registered on the edge entering DRIVE):
  - CLEAR: J=0, K=all-ones.
  - LOAD: J=DATA, K=~DATA.
  - TOGGLE: J=K=DATA.
  - COUNT: J[i]=K[i]=AND of Q_IN[i-1:0]; bit 0 is always 1. This gives an increment by 1 mod 2^WIDTH, so all-ones wraps to 0.
- **DRIVE** (1 cycle). The bank samples J/K at the next edge.
  - That edge sets J=K=0, sets rem=rem-1, and moves to HOLD.
- **HOLD** (1 cycle). Q_IN now reflects the completed step.
  - If rem==0, the next edge goes to DONE.
  - Otherwise the next edge computes new J/K from Q_IN and goes to DRIVE.
- **DONE.** DONE=1 and BUSY=1 for one cycle, then the next edge goes to IDLE.
  - START is ignored in the DONE cycle.
- **START while busy.** Ignored; it does not queue.
- **Latched inputs.** OP, DATA and STEPS are latched, so changes after acceptance have no effect.
- **rem arithmetic.** Unsigned CNT_W bits, and it never underflows. STEPS=2^CNT_W-1 is legal.
- **Asynchronous RST** (at any time, including mid-command):
  - state=IDLE; J=0; K=0; BUSY=0; DONE=0; rem=0; latched OP/DATA=0.
  - The bank itself is not reset by this block. Its value after a mid-command reset is whatever it held at the last completed sample.

## Timing
- **Reset values:** J=0, K=0, BUSY=0, DONE=0.
- **Step cost:** each step takes 2 cycles (DRIVE + HOLD). J/K are never asserted on two consecutive edges.
- **Edge numbering:** the accept edge is edge 0.
  - Step k is driven during cycle 2k-1, and the bank updates at edge 2k-1.
  - HOLD ends at edge 2k.
  - For n steps, DONE is high in the cycle after edge 2n, and the block is in IDLE after edge 2n+1.
- **CLEAR/LOAD:** bank updated at edge 1; DONE high after edge 2; IDLE after edge 3.
- **STEPS=0 (COUNT/TOGGLE):** DONE high after edge 0; IDLE after edge 1.
- **BUSY:** rises after edge 0 and falls after the edge that leaves DONE.
- **Back-to-back commands:** a new START is accepted at the first edge where the block is in IDLE. The minimum command-to-command spacing is 2n+2 cycles.

## Test plan
- **LOAD:** RST pulse, then LOAD DATA=4'b1010. Expect J=1010, K=0101 for exactly 1 cycle; bank Q=1010 after edge 1; DONE 1 cycle after edge 2; BUSY for 3 cycles.
- **COUNT with wrap:** from Q=4'b1110, COUNT STEPS=3. Expect Q sequence 1111, 0000, 0001; DONE after edge 6; J=K=0 in every HOLD cycle.
- **TOGGLE, including zero steps:**
  - From Q=0000, TOGGLE DATA=0110 STEPS=2. Expect Q=0110, then 0000.
  - TOGGLE STEPS=0. Expect DONE after edge 0, J/K never nonzero, Q unchanged.
- **Ignored START:** from Q=0101, CLEAR. Expect K=1111, J=0000; Q=0000. START pulses while BUSY (including in the DONE cycle) are ignored: no second command runs.
- **Mid-command reset:** COUNT STEPS=10 from 0000, assert RST asynchronously mid-DRIVE after 3 completed steps. Expect J=K=BUSY=DONE=0 immediately, IDLE, and Q holding its last completed value with no further changes. A new START is then accepted normally.
- **Back-to-back commands:** LOAD 0011 immediately followed by COUNT STEPS=1, with START held high continuously. Expect the second command accepted at the first IDLE edge and final Q=0100.

Source files
------------

// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - J/K drive sequencer for a bank of jk flip-flops
// Runs CLEAR/LOAD/COUNT/TOGGLE as DRIVE+HOLD step pairs with a BUSY/DONE handshake.
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] DATA,
    input  logic [CNT_W-1:0] STEPS,
    input  logic [WIDTH-1:0] Q_IN,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_COUNT = 2'b10;

    state_t             state, state_n;
    logic [1:0]         op_q, op_n;
    logic [WIDTH-1:0]   data_q, data_n;
    logic [CNT_W-1:0]   rem, rem_n;
    logic [2*WIDTH-1:0] jk_n;

    // Returns {J, K} for one step; COUNT toggles every bit below which all bits are set.
    function automatic logic [2*WIDTH-1:0] step_jk(input logic [1:0]       op,
                                                   input logic [WIDTH-1:0] data,
                                                   input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] carry_mask;
        logic             carry;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            carry_mask[i] = carry;
            carry         = carry & q[i];
        end
        case (op)
            OP_CLEAR: step_jk = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
            OP_LOAD:  step_jk = {data, ~data};
            OP_COUNT: step_jk = {carry_mask, carry_mask};
            default:  step_jk = {data, data};
        endcase
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            data_q <= '0;
            rem    <= '0;
            J      <= '0;
            K      <= '0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            data_q <= data_n;
            rem    <= rem_n;
            J      <= jk_n[2*WIDTH-1:WIDTH];
            K      <= jk_n[WIDTH-1:0];
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op_q;
        data_n  = data_q;
        rem_n   = rem;
        jk_n    = '0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    op_n   = OP;
                    data_n = DATA;
                    rem_n  = OP[1] ? STEPS : CNT_W'(1);
                    // Zero-step COUNT/TOGGLE completes without ever touching the bank.
                    if (OP[1] && (STEPS == '0)) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_DRIVE;
                        jk_n    = step_jk(OP, DATA, Q_IN);
                    end
                end
            end
            ST_DRIVE: begin
                rem_n   = (rem != '0) ? rem - 1'b1 : rem;
                state_n = ST_HOLD;
            end
            ST_HOLD: begin
                if (rem == '0) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_DRIVE;
                    jk_n    = step_jk(op_q, data_q, Q_IN);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign BUSY = (state != ST_IDLE);
    assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - scoreboard bench for jk_bank_sequencer with a modelled jk bank
module tb_jk_bank_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_COUNT  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             START = 1'b0;
    logic [1:0]       OP = '0;
    logic [WIDTH-1:0] DATA = '0;
    logic [CNT_W-1:0] STEPS = '0;
    logic [WIDTH-1:0] Q_IN;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic             BUSY;
    logic             DONE;

    logic [WIDTH-1:0] bank_q = '0;
    logic [WIDTH-1:0] model_q = '0;
    int               err_cnt = 0;
    int               chk_cnt = 0;
    int               exp_step_q[$];
    int               exp_lat_q[$];

    jk_bank_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .OP    (OP),
        .DATA  (DATA),
        .STEPS (STEPS),
        .Q_IN  (Q_IN),
        .J     (J),
        .K     (K),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    assign Q_IN = bank_q;

    always @(posedge CLK) begin
        for (int i = 0; i < WIDTH; i++) begin
            case ({J[i], K[i]})
                2'b10:   bank_q[i] <= 1'b1;
                2'b01:   bank_q[i] <= 1'b0;
                2'b11:   bank_q[i] <= ~bank_q[i];
                default: bank_q[i] <= bank_q[i];
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_step(input logic [1:0] op,
                                                    input logic [WIDTH-1:0] data,
                                                    input logic [WIDTH-1:0] q);
        case (op)
            OP_CLEAR: model_step = '0;
            OP_LOAD:  model_step = data;
            OP_COUNT: model_step = q + 1'b1;
            default:  model_step = q ^ data;
        endcase
    endfunction

    task automatic push_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                            input logic [CNT_W-1:0] steps);
        int n;
        n = op[1] ? int'(steps) : 1;
        for (int s = 0; s < n; s++) begin
            model_q = model_step(op, data, model_q);
            exp_step_q.push_back(int'(model_q));
        end
        exp_lat_q.push_back(2 * n + 1);
    endtask

    // Leaves START high; caller returns in the cycle after the accept edge.
    task automatic start_cmd(input logic [1:0] op, input logic [WIDTH-1:0] data,
                             input logic [CNT_W-1:0] steps);
        OP    = op;
        DATA  = data;
        STEPS = steps;
        START = 1'b1;
        push_cmd(op, data, steps);
        @(negedge CLK);
    endtask

    task automatic finish_cmd(input string tag);
        int n;
        START = 1'b0;
        OP    = 2'($urandom);
        DATA  = 4'($urandom);
        STEPS = 8'($urandom);
        n = 0;
        while (BUSY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check_eq({tag, "_idle"}, BUSY, 1'b0);
        check_eq({tag, "_q"}, bank_q, model_q);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op,
                           input logic [WIDTH-1:0] data, input logic [CNT_W-1:0] steps);
        start_cmd(op, data, steps);
        finish_cmd(tag);
    endtask

    logic prev_jk = 1'b0;
    logic prev_done = 1'b0;
    int   busy_cnt = 0;

    always @(negedge CLK) begin
        logic jk_now;
        if (RST) begin
            prev_jk   = 1'b0;
            prev_done = 1'b0;
            busy_cnt  = 0;
        end else begin
            jk_now = (J != '0) || (K != '0);
            if (prev_jk) begin
                check_eq("jk_gap", jk_now, 1'b0);
                check_eq("step_pending", exp_step_q.size() > 0, 1'b1);
                if (exp_step_q.size() > 0)
                    check_eq("step_q", bank_q, exp_step_q.pop_front());
            end
            if (BUSY)
                busy_cnt++;
            if (prev_done) begin
                check_eq("busy_after_done", BUSY, 1'b0);
                busy_cnt = 0;
            end
            if (DONE) begin
                check_eq("done_pending", exp_lat_q.size() > 0, 1'b1);
                if (exp_lat_q.size() > 0)
                    check_eq("done_latency", busy_cnt, exp_lat_q.pop_front());
            end
            prev_done = DONE;
            prev_jk   = jk_now;
        end
    end

    initial begin
        #1;
        check_eq("rst_j", J, 4'h0);
        check_eq("rst_k", K, 4'h0);
        check_eq("rst_busy", BUSY, 1'b0);
        check_eq("rst_done", DONE, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        start_cmd(OP_LOAD, 4'b1010, 8'd0);
        check_eq("load_j", J, 4'b1010);
        check_eq("load_k", K, 4'b0101);
        START = 1'b0;
        @(negedge CLK);
        check_eq("load_hold_jk", {J, K}, 8'h00);
        finish_cmd("load");

        run_cmd("preset_e", OP_LOAD, 4'b1110, 8'd0);
        run_cmd("count_wrap", OP_COUNT, 4'b0000, 8'd3);

        run_cmd("clear0", OP_CLEAR, 4'b1111, 8'd0);
        run_cmd("toggle2", OP_TOGGLE, 4'b0110, 8'd2);
        run_cmd("toggle0", OP_TOGGLE, 4'b1111, 8'd0);

        run_cmd("preset_5", OP_LOAD, 4'b0101, 8'd0);
        start_cmd(OP_CLEAR, 4'b1001, 8'd0);
        check_eq("clear_j", J, 4'b0000);
        check_eq("clear_k", K, 4'b1111);
        OP   = OP_LOAD;
        DATA = 4'b1111;
        repeat (3) @(negedge CLK);
        START = 1'b0;
        finish_cmd("clear_ignore");
        repeat (3) @(negedge CLK);
        check_eq("no_requeue_busy", BUSY, 1'b0);

        run_cmd("preset_0", OP_CLEAR, 4'b0000, 8'd0);
        start_cmd(OP_COUNT, 4'b0000, 8'd10);
        START = 1'b0;
        repeat (6) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check_eq("mid_rst_j", J, 4'h0);
        check_eq("mid_rst_k", K, 4'h0);
        check_eq("mid_rst_busy", BUSY, 1'b0);
        check_eq("mid_rst_done", DONE, 1'b0);
        check_eq("mid_rst_left", exp_step_q.size(), 7);
        exp_step_q.delete();
        exp_lat_q.delete();
        model_q = 4'b0011;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        check_eq("mid_rst_q", bank_q, model_q);
        check_eq("mid_rst_idle", BUSY, 1'b0);
        run_cmd("post_rst", OP_TOGGLE, 4'b1001, 8'd1);

        start_cmd(OP_LOAD, 4'b0011, 8'd0);
        OP    = OP_COUNT;
        STEPS = 8'd1;
        DATA  = 4'b1100;
        push_cmd(OP_COUNT, DATA, STEPS);
        repeat (4) @(negedge CLK);
        check_eq("b2b_busy", BUSY, 1'b1);
        finish_cmd("b2b");
        check_eq("b2b_final", bank_q, 4'b0100);

        run_cmd("count20", OP_COUNT, 4'b0000, 8'd20);

        repeat (3) @(negedge CLK);
        check_eq("steps_drained", exp_step_q.size(), 0);
        check_eq("done_drained", exp_lat_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
